// File: rtl/sha256_mmio_pkg.sv
// Shared types and register-map constants for the SHA-256 MMIO bus master.
package sha256_mmio_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POLL_RDY,
        S_WR_DATA,
        S_WR_CTRL,
        S_POLL_VLD,
        S_RD_HASH,
        S_ERR,
        S_RESP
    } state_e;

    typedef enum logic [1:0] {
        B_IDLE,
        B_REQ,
        B_WAIT_R
    } bus_state_e;

    localparam logic [4:0] IDX_CTRL  = 5'd0;
    localparam logic [4:0] IDX_DATA0 = 5'd1;
    localparam logic [4:0] IDX_VALID = 5'd17;
    localparam logic [4:0] IDX_HASH0 = 5'd18;

    localparam logic [63:0] CTRL_INIT = 64'h1;
    localparam logic [63:0] CTRL_NEXT = 64'h2;

    // Registers sit on 8-byte boundaries.
    function automatic logic [7:0] idx_to_addr(input logic [4:0] idx);
        return {idx, 3'b000};
    endfunction

endpackage

// File: rtl/sha256_mmio_bus_port.sv
// Single-outstanding req/gnt/rvalid sequencer. The FSM hands it one access
// via start_i (only while idle) and sees completion as a one-cycle done_o.
module sha256_mmio_bus_port
    import sha256_mmio_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        start_we_i,
    input  logic [7:0]  start_addr_i,
    input  logic [63:0] start_wdata_i,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [7:0]  bus_addr_o,
    output logic [63:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [63:0] bus_rdata_i
);

    bus_state_e state_q, state_d;
    logic       unused_rdata_hi;

    // Access sequencer state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= B_IDLE;
        else       state_q <= state_d;
    end

    // Capture the access when it is launched so address/data hold steady until grant.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus_we_o    <= 1'b0;
            bus_addr_o  <= 8'd0;
            bus_wdata_o <= 64'd0;
        end else if (state_q == B_IDLE && start_i) begin
            bus_we_o    <= start_we_i;
            bus_addr_o  <= start_addr_i;
            bus_wdata_o <= start_wdata_i;
        end
    end

    // Writes finish on grant, reads on rvalid; rvalid while idle is dropped.
    always_comb begin
        state_d = state_q;
        done_o  = 1'b0;
        case (state_q)
            B_IDLE:   if (start_i) state_d = B_REQ;
            B_REQ: begin
                if (bus_gnt_i) begin
                    if (bus_we_o) begin
                        done_o  = 1'b1;
                        state_d = B_IDLE;
                    end else begin
                        state_d = B_WAIT_R;
                    end
                end
            end
            B_WAIT_R: begin
                if (bus_rvalid_i) begin
                    done_o  = 1'b1;
                    state_d = B_IDLE;
                end
            end
            default:  state_d = B_IDLE;
        endcase
    end

    assign bus_req_o       = (state_q == B_REQ);
    assign rdata_o         = bus_rdata_i[31:0];
    assign unused_rdata_hi = ^bus_rdata_i[63:32];

endmodule

// File: rtl/sha256_mmio_master.sv
// Drives the SHA-256 peripheral: wait ready, load block, kick, poll valid, read digest.
//
//  state      | meaning
//  S_IDLE     | waiting for a client command
//  S_POLL_RDY | polling CTRL bit0 (core ready)
//  S_WR_DATA  | writing the 16 block words
//  S_WR_CTRL  | writing init/next kick to CTRL
//  S_POLL_VLD | polling hashValid
//  S_RD_HASH  | reading the 8 digest words
//  S_ERR      | poll timeout, clear digest and flag error
//  S_RESP     | presenting result until client accepts
module sha256_mmio_master
    import sha256_mmio_pkg::*;
#(
    parameter int POLL_MAX = 1024,
    parameter int POLL_GAP = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cmd_valid_i,
    output logic         cmd_ready_o,
    input  logic         cmd_init_i,
    input  logic [511:0] cmd_block_i,
    output logic         rsp_valid_o,
    input  logic         rsp_ready_i,
    output logic [255:0] rsp_digest_o,
    output logic         rsp_err_o,
    output logic         bus_req_o,
    output logic         bus_we_o,
    output logic [7:0]   bus_addr_o,
    output logic [63:0]  bus_wdata_o,
    input  logic         bus_gnt_i,
    input  logic         bus_rvalid_i,
    input  logic [63:0]  bus_rdata_i
);

    localparam int PCW = $clog2(POLL_MAX + 1);
    localparam int GCW = $clog2(POLL_GAP + 1);

    state_e         state_q, state_d;
    logic [511:0]   block_q;
    logic           init_q;
    logic [255:0]   digest_q;
    logic           err_q;
    logic [PCW-1:0] poll_cnt_q;
    logic [GCW-1:0] gap_cnt_q;
    logic [3:0]     word_cnt_q;
    logic           pend_q;

    logic           start, start_we, done, poll_last;
    logic [7:0]     start_addr;
    logic [63:0]    start_wdata;
    logic [31:0]    rdata;

    assign poll_last = (poll_cnt_q == PCW'(1));

    sha256_mmio_bus_port u_bus_port (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start),
        .start_we_i    (start_we),
        .start_addr_i  (start_addr),
        .start_wdata_i (start_wdata),
        .done_o        (done),
        .rdata_o       (rdata),
        .bus_req_o     (bus_req_o),
        .bus_we_o      (bus_we_o),
        .bus_addr_o    (bus_addr_o),
        .bus_wdata_o   (bus_wdata_o),
        .bus_gnt_i     (bus_gnt_i),
        .bus_rvalid_i  (bus_rvalid_i),
        .bus_rdata_i   (bus_rdata_i)
    );

    // Next-state and access selection; a new access launches only once the previous one finished.
    always_comb begin
        state_d     = state_q;
        start       = 1'b0;
        start_we    = 1'b0;
        start_addr  = idx_to_addr(IDX_CTRL);
        start_wdata = 64'd0;
        case (state_q)
            S_IDLE: if (cmd_valid_i) state_d = S_POLL_RDY;
            S_POLL_RDY, S_POLL_VLD: begin
                start_addr = idx_to_addr((state_q == S_POLL_RDY) ? IDX_CTRL : IDX_VALID);
                start      = !pend_q && (gap_cnt_q == '0);
                if (done) begin
                    if (rdata[0])       state_d = (state_q == S_POLL_RDY) ? S_WR_DATA : S_RD_HASH;
                    else if (poll_last) state_d = S_ERR;
                end
            end
            S_WR_DATA: begin
                start_we    = 1'b1;
                start_addr  = idx_to_addr(IDX_DATA0 + {1'b0, word_cnt_q});
                start_wdata = {32'd0, block_q[{word_cnt_q, 5'b00000} +: 32]};
                start       = !pend_q;
                if (done && word_cnt_q == 4'd15) state_d = S_WR_CTRL;
            end
            S_WR_CTRL: begin
                start_we    = 1'b1;
                start_wdata = init_q ? CTRL_INIT : CTRL_NEXT;
                start       = !pend_q;
                if (done) state_d = S_POLL_VLD;
            end
            S_RD_HASH: begin
                start_addr = idx_to_addr(IDX_HASH0 + {2'b00, word_cnt_q[2:0]});
                start      = !pend_q;
                if (done && word_cnt_q[2:0] == 3'd7) state_d = S_RESP;
            end
            S_ERR:  state_d = S_RESP;
            S_RESP: if (rsp_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, command capture, counters and result registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            block_q    <= '0;
            init_q     <= 1'b0;
            digest_q   <= '0;
            err_q      <= 1'b0;
            poll_cnt_q <= '0;
            gap_cnt_q  <= '0;
            word_cnt_q <= '0;
            pend_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start)     pend_q <= 1'b1;
            else if (done) pend_q <= 1'b0;
            if (gap_cnt_q != '0) gap_cnt_q <= gap_cnt_q - GCW'(1);
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        block_q    <= cmd_block_i;
                        init_q     <= cmd_init_i;
                        digest_q   <= '0;
                        err_q      <= 1'b0;
                        poll_cnt_q <= PCW'(POLL_MAX);
                        gap_cnt_q  <= '0;
                        word_cnt_q <= '0;
                    end
                end
                S_POLL_RDY, S_POLL_VLD: begin
                    if (done && !rdata[0]) begin
                        poll_cnt_q <= poll_cnt_q - PCW'(1);
                        gap_cnt_q  <= GCW'(POLL_GAP);
                    end
                end
                S_WR_DATA: if (done) word_cnt_q <= word_cnt_q + 4'd1;
                S_WR_CTRL: begin
                    // Gap after the kick lets a stale hashValid drop before the first poll.
                    if (done) begin
                        poll_cnt_q <= PCW'(POLL_MAX);
                        gap_cnt_q  <= GCW'(POLL_GAP);
                    end
                end
                S_RD_HASH: begin
                    if (done) begin
                        digest_q[{word_cnt_q[2:0], 5'b00000} +: 32] <= rdata;
                        word_cnt_q <= word_cnt_q + 4'd1;
                    end
                end
                S_ERR: begin
                    digest_q <= '0;
                    err_q    <= 1'b1;
                end
                S_RESP: if (rsp_ready_i) err_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign cmd_ready_o  = (state_q == S_IDLE);
    assign rsp_valid_o  = (state_q == S_RESP);
    assign rsp_err_o    = err_q;
    assign rsp_digest_o = digest_q;

endmodule
